seg7_scan_ctrl: RTL and testbench
=================================

SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000, input clock frequency in Hz.
REQ-002 Parameter SCAN_HZ, default 1000, digit-advance rate in Hz; DIV = CLK_HZ/SCAN_HZ, with DIV >= 2.
REQ-003 Parameter DIGITS, default 6, number of digits (range 2..8); SEL_W = clog2(DIGITS).
REQ-004 Parameter BLINK_HZ, default 2, blink rate in Hz; BDIV = CLK_HZ/(2*BLINK_HZ).
REQ-005 Parameter BLANK_CYC, default 4, anti-ghost blanking cycles (range 0..DIV-1).
REQ-006 clk  in  1  system clock, rising edge.
REQ-007 rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
REQ-008 data_in  in  4*DIGITS  hex nibbles; nibble k drives digit k; digit 0 is least significant.
REQ-009 dp_in  in  DIGITS  decimal-point enables, one per digit.
REQ-010 blink_mask  in  DIGITS  digits that blink.
REQ-011 lzb_en  in  1  leading-zero blanking enable.
REQ-012 data_valid  in  1  single-cycle load strobe for data_in, dp_in and blink_mask.
REQ-013 seg  out  8  active-low segments: bit7 = dp, bits6..0 = g..a.
REQ-014 sel  out  SEL_W  binary index of the active digit (drives an external decoder).
REQ-015 frame_done  out  1  one-cycle pulse on each wrap of sel from DIGITS-1 to 0.

Function
REQ-016 Prescaler counts 0..DIV-1 and wraps; tick asserts for the single cycle in which the count equals DIV-1.
REQ-017 On each tick, sel increments; at DIGITS-1 it wraps to 0 and frame_done pulses in the same cycle as the tick.
REQ-018 Data path: on data_valid, the inputs load into a shadow register on that clock edge.
REQ-019 Frame boundary: on the frame-boundary tick (sel = DIGITS-1), the shadow register copies to the active register.
REQ-020 Tear-free display: data therefore becomes visible only at the start of the next frame.
REQ-021 If data_valid coincides with the frame-boundary tick, the active register takes the inputs directly (bypass) on that edge.
REQ-022 Back-to-back data_valid pulses within one frame: the last pulse wins.
REQ-023 Glyphs, hex 0..F: C0,F9,A4,B0,99,92,82,F8,80,90,88,83,C6,A1,86,8E on bits6..0 (bit7 per dp).
REQ-024 seg bit7 = ~dp_active[sel], unless the digit is blanked.
REQ-025 Leading-zero blanking: when lzb_en = 1, digit k>0 is blanked if its nibble and all higher nibbles are zero.
REQ-026 Digit 0 is never leading-zero blanked.
REQ-027 Blink: a counter 0..BDIV-1 toggles blink_phase on wrap; while blink_phase = 1, digits with the active blink_mask bit set are blanked.
REQ-028 Anti-ghost: for the first BLANK_CYC cycles after each tick, seg = 8'hFF.
REQ-029 A blanked digit drives seg = 8'hFF, dp included.
REQ-030 seg and sel are registered outputs; seg reflects the new sel one cycle after the sel change.

Reset
REQ-031 Asynchronous assertion resets: prescaler, blink counter, blink_phase, sel, shadow, active, frame_done to 0; seg to 8'hFF.
REQ-032 Deassertion is synchronised internally; the first tick occurs DIV cycles after release.
REQ-033 Reset mid-frame discards pending shadow data; the display restarts at digit 0 showing "0".

Structure
REQ-034 Package seg7_pkg holds the 16-entry glyph constant table and the SEG_OFF = 8'hFF constant.
REQ-035 Sub-module seg7_tick_div (parametrised terminal-count divider) is instantiated twice, once for scan and once for blink.

Verification (CLK_HZ=1000, SCAN_HZ=100, DIGITS=4, BLINK_HZ=5, BLANK_CYC=2)
REQ-036 Scan: after reset, sel follows 0,1,2,3,0 every 10 cycles; frame_done pulses every 40 cycles; seg = FF for 2 cycles after each tick.
REQ-037 Tear-free load: data_in = 16'h12AF with data_valid mid-frame -> the current frame keeps the old digits; the next frame shows seg = 8E,88,A4,F9 for sel 0..3.
REQ-038 Leading zeros: data_in = 16'h0005, lzb_en = 1 -> digit 0 = 92, digits 1..3 = FF; with lzb_en = 0, digits 1..3 = C0.
REQ-039 Blink and dp: blink_mask = 4'b0010, dp_in = 4'b0001, data = 16'h0000 -> digit 1 alternates C0/FF every 100 cycles; digit 0 = 40.
REQ-040 Bypass and reset: data_valid on the frame-boundary tick -> the new data shows at sel = 0 immediately; rst_n low mid-frame -> seg = FF and sel = 0 asynchronously, with no glitch on release.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan controller: glyph table and
// the all-segments-off code (segments are active-low).
package seg7_pkg;

  typedef logic [3:0] nibble_t;

  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Hex glyphs 0..F; bit7 is replaced by the decimal point at use.
  localparam logic [7:0] GLYPH [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  function automatic logic [7:0] seg_glyph(input nibble_t nib, input logic dp);
    logic [7:0] g;
    g = GLYPH[nib];
    return {~dp, g[6:0]};
  endfunction

endpackage

// File: rtl/seg7_tick_div.sv
// Terminal-count divider: counts 0..DIV-1 and asserts tick while the count
// sits at DIV-1.
module seg7_tick_div #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed seven-segment scanner with tear-free frame-aligned data update,
// leading-zero blanking, per-digit blink and anti-ghost blanking.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int CLK_HZ    = 50_000_000,
  parameter int SCAN_HZ   = 1000,
  parameter int DIGITS    = 6,
  parameter int BLINK_HZ  = 2,
  parameter int BLANK_CYC = 4,
  localparam int SEL_W    = $clog2(DIGITS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   data_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blink_mask,
  input  logic                  lzb_en,
  input  logic                  data_valid,
  output logic [7:0]            seg,
  output logic [SEL_W-1:0]      sel,
  output logic                  frame_done
);

  localparam int DIV  = CLK_HZ / SCAN_HZ;
  localparam int BDIV = CLK_HZ / (2 * BLINK_HZ);
  localparam int DW   = 4 * DIGITS;
  localparam int BW   = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;

  localparam logic [SEL_W-1:0] LAST_SEL   = SEL_W'(DIGITS - 1);
  localparam logic             BLANK_ON   = (BLANK_CYC > 0);
  localparam logic [BW-1:0]    BLANK_LOAD = (BLANK_CYC > 0) ? BW'(BLANK_CYC - 1) : '0;

  logic [1:0]        rst_sync;
  logic              rst_int_n;
  logic              scan_tick;
  logic              blink_tick;
  logic              frame_tick;
  logic              blink_phase;
  logic [BW-1:0]     blank_left;
  logic              blank_now;

  logic [DW-1:0]     data_sh;
  logic [DIGITS-1:0] dp_sh;
  logic [DIGITS-1:0] bm_sh;
  logic [DW-1:0]     data_act;
  logic [DIGITS-1:0] dp_act;
  logic [DIGITS-1:0] bm_act;

  logic [DW-1:0]     data_shift;
  logic [DIGITS-1:0] dp_shift;
  logic [DIGITS-1:0] bm_shift;
  logic              lz_blank;
  logic              blink_blank;
  logic [7:0]        seg_d;

  // Reset asserts immediately but releases two edges later, so every flop
  // below leaves reset on the same clean edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync <= '0;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign rst_int_n = rst_sync[1];

  seg7_tick_div #(.DIV(DIV)) u_scan_div (
    .clk   (clk),
    .rst_n (rst_int_n),
    .tick  (scan_tick)
  );

  seg7_tick_div #(.DIV(BDIV)) u_blink_div (
    .clk   (clk),
    .rst_n (rst_int_n),
    .tick  (blink_tick)
  );

  assign frame_tick = scan_tick && (sel == LAST_SEL);
  assign frame_done = frame_tick;

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      sel <= '0;
    end else if (scan_tick) begin
      sel <= (sel == LAST_SEL) ? '0 : sel + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      blink_phase <= 1'b0;
    end else if (blink_tick) begin
      blink_phase <= ~blink_phase;
    end
  end

  // Shadow captures every load; active only changes at the frame boundary,
  // taking a coincident load directly so it is not lost for a whole frame.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      data_sh  <= '0;
      dp_sh    <= '0;
      bm_sh    <= '0;
      data_act <= '0;
      dp_act   <= '0;
      bm_act   <= '0;
    end else begin
      if (data_valid) begin
        data_sh <= data_in;
        dp_sh   <= dp_in;
        bm_sh   <= blink_mask;
      end
      if (frame_tick) begin
        data_act <= data_valid ? data_in    : data_sh;
        dp_act   <= data_valid ? dp_in      : dp_sh;
        bm_act   <= data_valid ? blink_mask : bm_sh;
      end
    end
  end

  // The tick edge itself loads SEG_OFF; blank_left covers the remaining cycles.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      blank_left <= '0;
    end else if (scan_tick && BLANK_ON) begin
      blank_left <= BLANK_LOAD;
    end else if (blank_left != '0) begin
      blank_left <= blank_left - 1'b1;
    end
  end

  assign blank_now = (scan_tick && BLANK_ON) || (blank_left != '0);

  always_comb begin
    data_shift  = data_act >> {sel, 2'b00};
    dp_shift    = dp_act >> sel;
    bm_shift    = bm_act >> sel;
    lz_blank    = lzb_en && (sel != '0) && (data_shift == '0);
    blink_blank = blink_phase && bm_shift[0];
    seg_d       = seg_glyph(data_shift[3:0], dp_shift[0]);
    if (blank_now || lz_blank || blink_blank) begin
      seg_d = SEG_OFF;
    end
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      seg <= SEG_OFF;
    end else begin
      seg <= seg_d;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Randomised and directed bench for seg7_scan_ctrl against a time-indexed
// reference model of the display.
module tb_seg7_scan_ctrl;

  localparam int CLK_HZ    = 1000;
  localparam int SCAN_HZ   = 100;
  localparam int DIGITS    = 4;
  localparam int BLINK_HZ  = 5;
  localparam int BLANK_CYC = 2;
  localparam int DIV       = CLK_HZ / SCAN_HZ;
  localparam int BDIV      = CLK_HZ / (2 * BLINK_HZ);
  localparam int FRAME     = DIV * DIGITS;
  localparam int SYNC      = 2;  // release-synchroniser depth

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] data_in = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  blink_mask = '0;
  logic        lzb_en = 1'b0;
  logic        data_valid = 1'b0;
  logic [7:0]  seg;
  logic [1:0]  sel;
  logic        frame_done;

  int checks = 0;
  int failures = 0;
  int m = 0;  // edges since internal reset release

  typedef struct packed {
    logic [15:0] d;
    logic [3:0]  dp;
    logic [3:0]  bm;
  } load_s;

  int    ld_time[$];
  load_s ld_val[$];

  logic [7:0] glyph_tab [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  always #5 clk = ~clk;

  seg7_scan_ctrl #(
    .CLK_HZ(CLK_HZ), .SCAN_HZ(SCAN_HZ), .DIGITS(DIGITS),
    .BLINK_HZ(BLINK_HZ), .BLANK_CYC(BLANK_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .dp_in(dp_in),
    .blink_mask(blink_mask), .lzb_en(lzb_en), .data_valid(data_valid),
    .seg(seg), .sel(sel), .frame_done(frame_done)
  );

  function automatic logic [1:0] exp_sel(int t);
    if (t < 0) return 2'd0;
    return 2'((t / DIV) % DIGITS);
  endfunction

  function automatic logic exp_fd(int t);
    return (t >= 0) && ((t % FRAME) == FRAME - 1);
  endfunction

  // Shown content = newest load at or before the latest frame boundary.
  function automatic logic [7:0] exp_seg(int t);
    int p, s, b;
    load_s v;
    logic [15:0] sh;
    logic [7:0] g;
    if (t <= 0) return 8'hFF;
    if (t >= DIV && (t % DIV) < BLANK_CYC) return 8'hFF;
    p = t - 1;
    s = (p / DIV) % DIGITS;
    b = (p / FRAME) * FRAME;
    v = '0;
    if (b > 0) begin
      foreach (ld_time[i]) if (ld_time[i] <= b) v = ld_val[i];
    end
    sh = v.d >> (4 * s);
    if (lzb_en && s != 0 && sh == 16'h0) return 8'hFF;
    if (v.bm[s] && ((p / BDIV) % 2 == 1)) return 8'hFF;
    g = glyph_tab[sh[3:0]];
    return {~v.dp[s], g[6:0]};
  endfunction

  task automatic step();
    @(posedge clk);
    m++;
    if (data_valid) begin
      ld_time.push_back(m);
      ld_val.push_back(load_s'{d: data_in, dp: dp_in, bm: blink_mask});
    end
    @(negedge clk);
    data_valid = 1'b0;
  endtask

  task automatic load(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bm);
    data_in = d;
    dp_in = dp;
    blink_mask = bm;
    data_valid = 1'b1;
  endtask

  task automatic test_reset();
    logic [10:0] got, exp;
    int first;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    got = {seg, sel, frame_done};
    checks++;
    if (got !== {8'hFF, 2'd0, 1'b0}) begin
      failures++;
      $display("FAIL reset_hold got=%h exp=%h", got, {8'hFF, 2'd0, 1'b0});
    end
    rst_n = 1'b1;
    m = -SYNC;
    first = -1;
    repeat (DIV + SYNC + 6) begin
      step();
      if (first < 0 && sel == 2'd1) first = m + SYNC;
      got = {seg, sel, frame_done};
      exp = {exp_seg(m), exp_sel(m), exp_fd(m)};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL reset_release m=%0d got=%h exp=%h", m, got, exp);
      end
    end
    checks++;
    if (first !== DIV + SYNC) begin
      failures++;
      $display("FAIL first_tick got=%0d exp=%0d", first, DIV + SYNC);
    end
  endtask

  task automatic test_scan();
    logic [10:0] got, exp;
    int last_fd;
    last_fd = -1;
    repeat (3 * FRAME) begin
      step();
      got = {seg, sel, frame_done};
      exp = {exp_seg(m), exp_sel(m), exp_fd(m)};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL scan m=%0d got=%h exp=%h", m, got, exp);
      end
      if (frame_done) begin
        if (last_fd >= 0) begin
          checks++;
          if (m - last_fd != FRAME) begin
            failures++;
            $display("FAIL frame_period got=%0d exp=%0d", m - last_fd, FRAME);
          end
        end
        last_fd = m;
      end
    end
  endtask

  task automatic test_tear_free();
    logic [10:0] got, exp;
    logic [7:0] tf_exp [4];
    int nb;
    tf_exp = '{8'h8E, 8'h88, 8'hA4, 8'hF9};
    lzb_en = 1'b0;
    while (m % FRAME != 15) begin
      step();
      got = {seg, sel, frame_done};
      exp = {exp_seg(m), exp_sel(m), exp_fd(m)};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL tear_align m=%0d got=%h exp=%h", m, got, exp);
      end
    end
    load(16'h12AF, 4'b0000, 4'b0000);
    nb = (m / FRAME + 1) * FRAME;
    repeat (2 * FRAME) begin
      step();
      got = {seg, sel, frame_done};
      exp = {exp_seg(m), exp_sel(m), exp_fd(m)};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL tear_model m=%0d got=%h exp=%h", m, got, exp);
      end
      if (m % DIV == 5 && m < nb) begin
        checks++;
        if (seg !== 8'hC0) begin
          failures++;
          $display("FAIL tear_old m=%0d got=%h exp=%h", m, seg, 8'hC0);
        end
      end
      if (m % DIV == 5 && m >= nb && m < nb + FRAME) begin
        checks++;
        if (seg !== tf_exp[(m - nb) / DIV]) begin
          failures++;
          $display("FAIL tear_new m=%0d got=%h exp=%h", m, seg, tf_exp[(m - nb) / DIV]);
        end
      end
    end
  endtask

  task automatic test_lzb();
    logic [10:0] got, exp;
    logic [7:0] on_exp [4];
    logic [7:0] off_exp [4];
    int nb;
    on_exp = '{8'h92, 8'hFF, 8'hFF, 8'hFF};
    off_exp = '{8'h92, 8'hC0, 8'hC0, 8'hC0};
    lzb_en = 1'b1;
    load(16'h0005, 4'b0000, 4'b0000);
    nb = (m / FRAME + 1) * FRAME;
    repeat (3 * FRAME) begin
      step();
      got = {seg, sel, frame_done};
      exp = {exp_seg(m), exp_sel(m), exp_fd(m)};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL lzb_model m=%0d got=%h exp=%h", m, got, exp);
      end
      if (m >= nb && m % DIV == 5) begin
        checks++;
        if (seg !== (lzb_en ? on_exp[(m / DIV) % DIGITS] : off_exp[(m / DIV) % DIGITS])) begin
          failures++;
          $display("FAIL lzb_digit m=%0d lzb=%b got=%h", m, lzb_en, seg);
        end
      end
      if (m == nb + 2 * FRAME - 1) lzb_en = 1'b0;
      if (m == nb + FRAME - 1) lzb_en = 1'b0;
    end
  endtask

  task automatic test_blink_dp();
    logic [10:0] got, exp;
    logic seen_on, seen_off;
    seen_on = 1'b0;
    seen_off = 1'b0;
    lzb_en = 1'b0;
    load(16'h0000, 4'b0001, 4'b0010);
    repeat (2 * FRAME) step();
    repeat (5 * BDIV) begin
      step();
      got = {seg, sel, frame_done};
      exp = {exp_seg(m), exp_sel(m), exp_fd(m)};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL blink_model m=%0d got=%h exp=%h", m, got, exp);
      end
      if (m % FRAME == 5) begin
        checks++;
        if (seg !== 8'h40) begin
          failures++;
          $display("FAIL dp_digit0 m=%0d got=%h exp=%h", m, seg, 8'h40);
        end
      end
      if (m % FRAME == 15) begin
        if (seg === 8'hC0) seen_on = 1'b1;
        if (seg === 8'hFF) seen_off = 1'b1;
      end
    end
    checks++;
    if ({seen_on, seen_off} !== 2'b11) begin
      failures++;
      $display("FAIL blink_alternate got=%b exp=%b", {seen_on, seen_off}, 2'b11);
    end
  endtask

  task automatic test_bypass();
    logic [10:0] got, exp;
    lzb_en = 1'b0;
    while (m % FRAME != FRAME - 1) begin
      step();
      got = {seg, sel, frame_done};
      exp = {exp_seg(m), exp_sel(m), exp_fd(m)};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL bypass_align m=%0d got=%h exp=%h", m, got, exp);
      end
    end
    load(16'h000C, 4'b0000, 4'b0000);
    repeat (DIV) begin
      step();
      got = {seg, sel, frame_done};
      exp = {exp_seg(m), exp_sel(m), exp_fd(m)};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL bypass_model m=%0d got=%h exp=%h", m, got, exp);
      end
      if (m % FRAME == BLANK_CYC) begin
        checks++;
        if (seg !== 8'hC6) begin
          failures++;
          $display("FAIL bypass_digit0 m=%0d got=%h exp=%h", m, seg, 8'hC6);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] got, exp;
    int nb;
    while (m % FRAME != 5) step();
    load(16'h1111, 4'b0000, 4'b0000);
    step();
    load(16'h2222, 4'b0000, 4'b0000);
    nb = (m / FRAME + 1) * FRAME;
    repeat (2 * FRAME) begin
      step();
      got = {seg, sel, frame_done};
      exp = {exp_seg(m), exp_sel(m), exp_fd(m)};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL b2b_model m=%0d got=%h exp=%h", m, got, exp);
      end
      if (m >= nb && m < nb + FRAME && m % DIV == 5) begin
        checks++;
        if (seg !== 8'hA4) begin
          failures++;
          $display("FAIL b2b_last_wins m=%0d got=%h exp=%h", m, seg, 8'hA4);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [10:0] got, exp;
    repeat (15 * FRAME) begin
      step();
      got = {seg, sel, frame_done};
      exp = {exp_seg(m), exp_sel(m), exp_fd(m)};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL random m=%0d got=%h exp=%h", m, got, exp);
      end
      if ($urandom_range(0, 11) == 0 || (m % FRAME == FRAME - 1 && $urandom_range(0, 2) == 0))
        load(16'($urandom), 4'($urandom), 4'($urandom));
      if ($urandom_range(0, 49) == 0) lzb_en = 1'($urandom);
    end
  endtask

  task automatic test_reset_mid();
    logic [10:0] got, exp;
    lzb_en = 1'b1;
    while (m % FRAME != 17) step();
    load(16'h4321, 4'b0000, 4'b0000);
    repeat (5) step();
    #2;
    rst_n = 1'b0;
    #1;
    got = {seg, sel, frame_done};
    checks++;
    if (got !== {8'hFF, 2'd0, 1'b0}) begin
      failures++;
      $display("FAIL reset_async got=%h exp=%h", got, {8'hFF, 2'd0, 1'b0});
    end
    @(negedge clk);
    @(negedge clk);
    got = {seg, sel, frame_done};
    checks++;
    if (got !== {8'hFF, 2'd0, 1'b0}) begin
      failures++;
      $display("FAIL reset_mid_hold got=%h exp=%h", got, {8'hFF, 2'd0, 1'b0});
    end
    ld_time.delete();
    ld_val.delete();
    rst_n = 1'b1;
    m = -SYNC;
    repeat (2 * FRAME + 5) begin
      step();
      got = {seg, sel, frame_done};
      exp = {exp_seg(m), exp_sel(m), exp_fd(m)};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL reset_restart m=%0d got=%h exp=%h", m, got, exp);
      end
      if (m == FRAME + 5) begin
        checks++;
        if (seg !== 8'hC0) begin
          failures++;
          $display("FAIL reset_discard m=%0d got=%h exp=%h", m, seg, 8'hC0);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_tear_free();
    test_lzb();
    test_blink_dp();
    test_bypass();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
